// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_ctrl
// Purpose  : Iterative AES-128 encryption controller. One round per clock
//            over a registered 128-bit state. Round keys are fetched from an
//            external key-schedule store addressed by rk_idx.
// Options  : AES_BLK_CNT_EN - adds a saturating 32-bit completed-block
//            counter on output blk_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_ctrl #(
    parameter int NR     = 10,
    parameter int BYTE_W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
`ifdef AES_BLK_CNT_EN
    output logic [31:0]  blk_cnt,
`endif
    output logic         busy
);

    localparam int          c_NBYTES = 128 / BYTE_W;
    localparam logic [3:0]  c_NR     = 4'(NR);
    localparam logic [3:0]  c_NR_M1  = 4'(NR - 1);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_ROUND  = 2'd1;
    localparam logic [1:0]  S_FINAL  = 2'd2;
    localparam logic [1:0]  S_DONE   = 2'd3;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [1:0]   r_fsm;
    logic [1:0]   w_fsm_nxt;
    logic [3:0]   r_round;
    logic [3:0]   w_round_nxt;
    logic [127:0] r_state;
    logic [127:0] w_state_nxt;

    logic [127:0] w_sb;
    logic [127:0] w_sr;
    logic [127:0] w_mc;

    // Table lookup: (255 - b) * 8 is simply {~b, 3'b000}.
    function automatic logic [7:0] sbox_lu(input logic [7:0] b);
        return c_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // SubBytes on the registered state.
    for (genvar gi = 0; gi < c_NBYTES; gi++) begin : g_sub_bytes
        assign w_sb[127-8*gi -: 8] = sbox_lu(r_state[127-8*gi -: 8]);
    end

    // ShiftRows: row r of column c takes row r of column (c + r) mod 4.
    for (genvar gr = 0; gr < 4; gr++) begin : g_shift_row
        for (genvar gc = 0; gc < 4; gc++) begin : g_shift_col
            assign w_sr[127-8*(gr+4*gc) -: 8] = w_sb[127-8*(gr+4*((gc+gr)%4)) -: 8];
        end
    end

    // MixColumns, one column of four bytes per iteration.
    for (genvar gc = 0; gc < 4; gc++) begin : g_mix_col
        logic [7:0] w_a0, w_a1, w_a2, w_a3;
        assign w_a0 = w_sr[127-32*gc      -: 8];
        assign w_a1 = w_sr[127-32*gc - 8  -: 8];
        assign w_a2 = w_sr[127-32*gc - 16 -: 8];
        assign w_a3 = w_sr[127-32*gc - 24 -: 8];
        assign w_mc[127-32*gc      -: 8] = xtime(w_a0) ^ mul3(w_a1) ^ w_a2 ^ w_a3;
        assign w_mc[127-32*gc - 8  -: 8] = w_a0 ^ xtime(w_a1) ^ mul3(w_a2) ^ w_a3;
        assign w_mc[127-32*gc - 16 -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ mul3(w_a3);
        assign w_mc[127-32*gc - 24 -: 8] = mul3(w_a0) ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end

    // Next-state, round counter and datapath steering.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_round_nxt = r_round;
        w_state_nxt = r_state;
        case (r_fsm)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = in_data ^ rk;
                    w_round_nxt = 4'd1;
                    w_fsm_nxt   = S_ROUND;
                end
            end
            S_ROUND: begin
                w_state_nxt = w_mc ^ rk;
                w_round_nxt = r_round + 4'd1;
                // >= keeps the counter bounded even if it were ever corrupted
                if (r_round >= c_NR_M1) begin
                    w_fsm_nxt = S_FINAL;
                end
            end
            S_FINAL: begin
                w_state_nxt = w_sr ^ rk;
                w_fsm_nxt   = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_fsm_nxt   = S_IDLE;
                    w_round_nxt = 4'd0;
                end
            end
            default: begin
                w_fsm_nxt   = S_IDLE;
                w_round_nxt = 4'd0;
                w_state_nxt = '0;
            end
        endcase
    end

    // Round-key index derived from registered state only.
    always_comb begin
        rk_idx = 4'd0;
        case (r_fsm)
            S_ROUND: rk_idx = r_round;
            S_FINAL: rk_idx = c_NR;
            default: rk_idx = 4'd0;
        endcase
    end

    // State, round counter and FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm   <= S_IDLE;
            r_round <= 4'd0;
            r_state <= '0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_round <= w_round_nxt;
            r_state <= w_state_nxt;
        end
    end

    assign in_ready  = (r_fsm == S_IDLE);
    assign busy      = (r_fsm != S_IDLE);
    assign out_valid = (r_fsm == S_DONE);
    // Intermediate round states are never exposed on the output bus.
    assign out_data  = out_valid ? r_state : '0;

`ifdef AES_BLK_CNT_EN
    logic        w_out_fire;
    logic [31:0] r_blk_cnt;

    assign w_out_fire = out_valid & out_ready;

    // Saturating count of delivered ciphertext blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk_cnt <= 32'd0;
        end else if (w_out_fire && (r_blk_cnt != 32'hFFFF_FFFF)) begin
            r_blk_cnt <= r_blk_cnt + 32'd1;
        end
    end

    assign blk_cnt = r_blk_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_ctrl
// Purpose  : Directed self-checking bench for aes_round_ctrl using known
//            AES-128 answer vectors. Round keys are expanded here and served
//            combinationally by rk_idx. Counter checks are compiled only when
//            AES_BLK_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

    localparam logic [127:0] c_KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_CT0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
`ifdef AES_BLK_CNT_EN
    logic [31:0]  blk_cnt;
`endif

    logic [127:0] rk_tab [0:15];
    int           n_vec = 0;
    int           n_err = 0;
    int           exp_blk = 0;

    aes_round_ctrl #(.NR(10), .BYTE_W(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef AES_BLK_CNT_EN
        .blk_cnt   (blk_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign rk = rk_tab[rk_idx];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // GF(2^8) arithmetic used to build the S-box from first principles.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    task automatic rk_load(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
                t = t ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk_tab[r] = '0;
        for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Entered and left at 1 ns after a rising edge.
    task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] ct, input int stall, input string tag);
        int   lat = 0;
        logic seq_ok = 1'b1;
        logic hold_ok = 1'b1;
        rk_load(key);
        out_ready = (stall == 0);
        in_valid  = 1'b1;
        in_data   = pt;
        check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        check({tag, "_rkidx_idle"}, 128'(rk_idx), 128'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            if (rk_idx !== 4'(lat + 1) || in_ready !== 1'b0) seq_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'd10);
        check({tag, "_rkidx_seq"}, 128'(seq_ok), 128'd1);
        check({tag, "_ct"}, out_data, ct);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_data !== ct || in_ready !== 1'b0) hold_ok = 1'b0;
`ifdef AES_BLK_CNT_EN
            if (blk_cnt !== 32'(exp_blk)) hold_ok = 1'b0;
`endif
        end
        if (stall > 0) check({tag, "_stall_hold"}, 128'(hold_ok), 128'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_blk++;
        check({tag, "_ov_drop"}, 128'(out_valid), 128'd0);
        check({tag, "_ready_back"}, 128'(in_ready), 128'd1);
`ifdef AES_BLK_CNT_EN
        check({tag, "_blk_cnt"}, 128'(blk_cnt), 128'(exp_blk));
`endif
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        exp_blk = 0;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_data", out_data, 128'd0);
        check("rst_rk_idx", 128'(rk_idx), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int   n;
        logic seen;
        logic [127:0] got_a;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        rk_load(c_KEY1);
        #12;
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_in_ready", 128'(in_ready), 128'd1);
        check("reset_out_data", out_data, 128'd0);
`ifdef AES_BLK_CNT_EN
        check("reset_blk_cnt", 128'(blk_cnt), 128'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_block(c_KEY1, c_PT1, c_CT1, 0, "fips");
        run_block(c_KEY1, c_PT1, c_CT1, 5, "bp");

        // Second block presented while the first is still in flight.
        rk_load(c_KEY1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = c_PT1;
        @(posedge clk); #1;
        in_data = '0;
        n = 0;
        seen = 1'b0;
        got_a = '0;
        while (!in_ready && n < 40) begin
            if (out_valid && !seen) begin
                got_a = out_data;
                seen  = 1'b1;
                rk_load(128'd0);
            end
            @(posedge clk); #1;
            n++;
        end
        exp_blk++;
        check("busy_ct_a", got_a, c_CT1);
        check("busy_spacing", 128'(n + 1), 128'd12);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_ct_b", out_data, c_CT0);
        @(posedge clk); #1;
        exp_blk++;
        check("busy_done", 128'(out_valid), 128'd0);

        run_block(128'd0, 128'd0, c_CT0, 0, "zero");

        // Reset while rounds are in progress.
        rk_load(c_KEY1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = c_PT1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        check("mid_rk_idx", 128'(rk_idx), 128'd5);
        pulse_reset();
        run_block(c_KEY1, c_PT1, c_CT1, 0, "post_rst");

        // Reset while a ciphertext is stalled at the output.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = c_PT1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_pre_rst", 128'(out_valid), 128'd1);
        pulse_reset();

`ifdef AES_BLK_CNT_EN
        run_block(c_KEY1, c_PT1, c_CT1, 0, "cnt1");
        run_block(128'd0, 128'd0, c_CT0, 0, "cnt2");
        run_block(c_KEY1, c_PT1, c_CT1, 4, "cnt3");
        check("cnt_three", 128'(blk_cnt), 128'd3);
        pulse_reset();
        check("cnt_cleared", 128'(blk_cnt), 128'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
